// File: rtl/money.sv
// Coin-operated vending credit counter: accumulates coin values into a saturating
// 8-bit balance and emits a one-cycle dispense pulse when a purchase is accepted.
module money #(
    parameter logic [7:0] PRICE = 8'd15,
    parameter logic [7:0] V0    = 8'd1,
    parameter logic [7:0] V1    = 8'd2,
    parameter logic [7:0] V2    = 8'd5,
    parameter logic [7:0] V3    = 8'd10
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] money_in,
    input  logic       button,
    output logic       flag,
    output logic [7:0] in_money_val
);

    logic [3:0] r_moneyPrev;
    logic       r_buttonPrev;
    logic [7:0] r_balance;
    logic       r_flag;

    logic [3:0] w_coinRise;
    logic       w_pressEvent;
    logic [7:0] w_coinValue;
    logic       w_accept;
    logic [8:0] w_nextSum;
    logic [7:0] w_nextBalance;

    assign w_coinRise   = money_in & ~r_moneyPrev;
    assign w_pressEvent = r_buttonPrev & ~button;

    // Only a lone rising coin line carries value; simultaneous rises are rejected.
    always_comb begin
        w_coinValue = 8'd0;
        unique case (w_coinRise)
            4'b0001: w_coinValue = V0;
            4'b0010: w_coinValue = V1;
            4'b0100: w_coinValue = V2;
            4'b1000: w_coinValue = V3;
            default: w_coinValue = 8'd0;
        endcase
    end

    assign w_accept = en && w_pressEvent && (r_balance >= PRICE);

    // Acceptance guarantees balance >= PRICE, so the subtraction never underflows.
    always_comb begin
        w_nextSum = {1'b0, r_balance} + {1'b0, w_coinValue};
        if (w_accept) begin
            w_nextSum = w_nextSum - {1'b0, PRICE};
        end
        w_nextBalance = w_nextSum[8] ? 8'hFF : w_nextSum[7:0];
    end

    // Edge-detect copies track the inputs every cycle, so events seen while
    // disabled are dropped rather than replayed once en returns.
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_moneyPrev  <= 4'b0000;
            r_buttonPrev <= 1'b1;
            r_balance    <= 8'd0;
            r_flag       <= 1'b0;
        end else begin
            r_moneyPrev  <= money_in;
            r_buttonPrev <= button;
            r_flag       <= w_accept;
            if (en) begin
                r_balance <= w_nextBalance;
            end
        end
    end

    assign flag         = r_flag;
    assign in_money_val = r_balance;

endmodule

// File: tb/tb_money.sv
// Directed, table-driven bench for the money credit counter with hand-computed
// expected balances, plus a saturation sequence.
module tb_money;

    logic       sclk;
    logic       rst;
    logic       en;
    logic [3:0] money_in;
    logic       button;
    logic       flag;
    logic [7:0] in_money_val;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] money;
        logic       button;
        logic       expFlag;
        logic [7:0] expBal;
    } vec_t;

    vec_t vecs[$];

    money dut (
        .sclk         (sclk),
        .rst          (rst),
        .en           (en),
        .money_in     (money_in),
        .button       (button),
        .flag         (flag),
        .in_money_val (in_money_val)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    // Inputs change on the falling edge; outputs are read just after the rising edge.
    task automatic applyStimulus(input logic r, input logic e, input logic [3:0] m, input logic b);
        @(negedge sclk);
        rst      = r;
        en       = e;
        money_in = m;
        button   = b;
        @(posedge sclk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic expFlag, input logic [7:0] expBal);
        checkCount++;
        if (flag === expFlag && in_money_val === expBal) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: flag=%0b bal=%0d, expected flag=%0b bal=%0d",
                     name, flag, in_money_val, expFlag, expBal);
        end
    endtask

    function automatic void addVec(input logic r, input logic e, input logic [3:0] m,
                                   input logic b, input logic f, input logic [7:0] bal);
        vecs.push_back('{r, e, m, b, f, bal});
    endfunction

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        money_in = 4'b0000;
        button   = 1'b1;

        //      rst en  money    btn  flag bal
        addVec(1, 0, 4'b0000, 1, 0, 8'd0);    // reset state
        addVec(0, 1, 4'b1000, 1, 0, 8'd10);   // coin 10
        addVec(0, 1, 4'b0100, 1, 0, 8'd15);   // coin 5
        addVec(0, 1, 4'b0000, 1, 0, 8'd15);
        addVec(0, 1, 4'b0000, 0, 1, 8'd0);    // purchase at exactly PRICE
        addVec(0, 1, 4'b0000, 0, 0, 8'd0);    // held button, no second pulse
        addVec(0, 1, 4'b0000, 1, 0, 8'd0);
        addVec(0, 1, 4'b0100, 1, 0, 8'd5);
        addVec(0, 1, 4'b0000, 1, 0, 8'd5);
        addVec(0, 1, 4'b0000, 0, 0, 8'd5);    // insufficient credit
        addVec(0, 1, 4'b0000, 1, 0, 8'd5);
        addVec(0, 1, 4'b0001, 1, 0, 8'd6);    // held coin counts once
        addVec(0, 1, 4'b0001, 1, 0, 8'd6);
        addVec(0, 1, 4'b0001, 1, 0, 8'd6);
        addVec(0, 1, 4'b0001, 1, 0, 8'd6);
        addVec(0, 1, 4'b0001, 1, 0, 8'd6);
        addVec(0, 1, 4'b0000, 1, 0, 8'd6);
        addVec(0, 1, 4'b0011, 1, 0, 8'd6);    // two lines rise together: rejected
        addVec(0, 1, 4'b0000, 1, 0, 8'd6);
        addVec(0, 0, 4'b1000, 1, 0, 8'd6);    // disabled coin ignored
        addVec(0, 0, 4'b0000, 0, 0, 8'd6);    // disabled press ignored
        addVec(0, 0, 4'b0000, 1, 0, 8'd6);
        addVec(0, 0, 4'b1000, 1, 0, 8'd6);    // edge seen while disabled...
        addVec(0, 1, 4'b1000, 1, 0, 8'd6);    // ...is not deferred
        addVec(0, 1, 4'b0000, 1, 0, 8'd6);
        addVec(0, 1, 4'b0100, 1, 0, 8'd11);
        addVec(0, 1, 4'b0000, 1, 0, 8'd11);
        addVec(0, 1, 4'b0010, 1, 0, 8'd13);
        addVec(0, 1, 4'b0000, 1, 0, 8'd13);
        addVec(0, 1, 4'b0010, 1, 0, 8'd15);
        addVec(1, 1, 4'b1000, 0, 0, 8'd0);    // reset beats coin and press
        addVec(0, 1, 4'b0000, 1, 0, 8'd0);
        addVec(0, 1, 4'b1000, 1, 0, 8'd10);
        addVec(0, 1, 4'b0000, 1, 0, 8'd10);
        addVec(0, 1, 4'b1000, 1, 0, 8'd20);
        addVec(0, 1, 4'b0000, 1, 0, 8'd20);
        addVec(0, 1, 4'b0100, 0, 1, 8'd10);   // press and coin together: 20-15+5
        addVec(0, 1, 4'b0000, 1, 0, 8'd10);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].money, vecs[i].button);
            checkOutput($sformatf("vec%0d", i), vecs[i].expFlag, vecs[i].expBal);
        end

        // Saturation: from 10, each pulse adds 10 until the balance clamps at 255.
        for (int p = 1; p <= 26; p++) begin
            applyStimulus(0, 1, 4'b1000, 1);
            if (p == 24) checkOutput("sat_250", 1'b0, 8'd250);
            if (p == 25) checkOutput("sat_clamp", 1'b0, 8'd255);
            applyStimulus(0, 1, 4'b0000, 1);
        end
        checkOutput("sat_hold", 1'b0, 8'd255);

        // Purchase plus coin at full balance: 255 - 15 + 10 = 250.
        applyStimulus(0, 1, 4'b1000, 0);
        checkOutput("sat_buy", 1'b1, 8'd250);
        applyStimulus(0, 1, 4'b0000, 1);
        checkOutput("sat_buy_after", 1'b0, 8'd250);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
